// File: rtl/booth_radix4_seq.sv
// -----------------------------------------------------------------------------
// booth_radix4_seq
//
// Iterative radix-4 Booth multiplier for the ALU multiply path. One operand
// pair is accepted in IDLE. The pair is retired DIGITS_PER_CYCLE Booth digits
// per RUN cycle through a shift/add datapath. The double-width product is then
// presented in DONE until the consumer takes it.
//
// Parameters
//   DATA_WIDTH        operand width W (even, >= 4)
//   DIGITS_PER_CYCLE  Booth digits retired per RUN cycle (1, 2 or 4)
//
// Ports
//   clock         rising-edge clock
//   clear         asynchronous active-high reset
//   start         operand strobe, taken only while in_ready = 1
//   signed_mode   1 = two's-complement operands, 0 = unsigned (sampled at accept)
//   multiplicand  operand M (sampled at accept)
//   multiplier    operand Q (sampled at accept)
//   in_ready      high only in IDLE
//   out_valid     high only in DONE
//   out_ready     consumer takes product while out_valid = 1
//   product       2W-bit result, registered, stable while out_valid = 1
//
// Optional feature
//   BOOTH_SEQ_EARLY_EXIT_EN : when defined, RUN checks before each step whether
//   the remaining multiplier bits {q, q_m1} are all equal. If they are, every
//   remaining digit is zero, so RUN jumps straight to DONE without adding.
//   When undefined, latency is fixed at S steps and no such comparator exists.
// -----------------------------------------------------------------------------
module booth_radix4_seq #(
    parameter int DATA_WIDTH       = 32,
    parameter int DIGITS_PER_CYCLE = 1
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      start,
    input  logic                      signed_mode,
    input  logic [DATA_WIDTH-1:0]     multiplicand,
    input  logic [DATA_WIDTH-1:0]     multiplier,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   product
);

    localparam int W        = DATA_WIDTH;
    // Accumulator and shifted multiplicand carry two guard bits above 2W so
    // that the unsigned-mode extension digit never overflows the datapath.
    localparam int ACC_W    = 2 * W + 2;
    localparam int Q_W      = W + 2;
    localparam int N_DIGITS = W / 2 + 1;
    localparam int STEPS    = (N_DIGITS + DIGITS_PER_CYCLE - 1) / DIGITS_PER_CYCLE;
    localparam int CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_next_s;

    logic [ACC_W-1:0]      acc_r;
    logic [ACC_W-1:0]      mshift_r;
    logic [Q_W-1:0]        q_r;
    logic                  q_m1_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [2*W-1:0]        product_r;

    logic [ACC_W-1:0]      ext_m_s;
    logic [Q_W-1:0]        ext_q_s;

    logic [ACC_W-1:0]      acc_walk_s;
    logic [ACC_W-1:0]      m_walk_s;
    logic [Q_W-1:0]        q_walk_s;
    logic                  q_m1_walk_s;

    logic                  early_exit_s;
    logic                  done_entry_s;
    logic [2*W-1:0]        result_s;

    // Radix-4 Booth recoding: selects the multiple of the shifted multiplicand
    // that corresponds to the digit window {q[1], q[0], q_m1}.
    function automatic logic [ACC_W-1:0] booth_addend(
        input logic [ACC_W-1:0] m,
        input logic [2:0]       sel
    );
        logic [ACC_W-1:0] m2;
        logic [ACC_W-1:0] res;
        m2 = {m[ACC_W-2:0], 1'b0};
        case (sel)
            3'b000, 3'b111: res = {ACC_W{1'b0}};
            3'b001, 3'b010: res = m;
            3'b011:         res = m2;
            3'b100:         res = {ACC_W{1'b0}} - m2;
            3'b101, 3'b110: res = {ACC_W{1'b0}} - m;
            default:        res = {ACC_W{1'b0}};
        endcase
        return res;
    endfunction

    // Operand extension: sign or zero fill depending on the requested mode.
    // M is filled to the full accumulator width so that the modular sum
    // produces the exact low 2W bits in both modes.
    always_comb begin
        if (signed_mode) begin
            ext_m_s = {{(ACC_W - W){multiplicand[W-1]}}, multiplicand};
            ext_q_s = {{2{multiplier[W-1]}}, multiplier};
        end else begin
            ext_m_s = {{(ACC_W - W){1'b0}}, multiplicand};
            ext_q_s = {2'b00, multiplier};
        end
    end

    // One RUN step: retire DIGITS_PER_CYCLE digits back to back, each digit
    // seeing the multiplicand and multiplier already shifted by its predecessor.
    always_comb begin
        acc_walk_s  = acc_r;
        m_walk_s    = mshift_r;
        q_walk_s    = q_r;
        q_m1_walk_s = q_m1_r;
        for (int d = 0; d < DIGITS_PER_CYCLE; d++) begin
            acc_walk_s  = acc_walk_s + booth_addend(m_walk_s, {q_walk_s[1:0], q_m1_walk_s});
            m_walk_s    = {m_walk_s[ACC_W-3:0], 2'b00};
            q_m1_walk_s = q_walk_s[1];
            q_walk_s    = {{2{q_walk_s[Q_W-1]}}, q_walk_s[Q_W-1:2]};
        end
    end

`ifdef BOOTH_SEQ_EARLY_EXIT_EN
    // The multiplier shifts arithmetically, so once {q, q_m1} is uniform every
    // remaining digit window is 000 or 111 and decodes to zero.
    assign early_exit_s = (&{q_r, q_m1_r}) | ~(|{q_r, q_m1_r});
`else
    assign early_exit_s = 1'b0;
`endif

    // On an early exit nothing is added in the final RUN cycle, so the result
    // comes from the accumulator as it stands rather than from the step sum.
    assign result_s     = early_exit_s ? acc_r[2*W-1:0] : acc_walk_s[2*W-1:0];
    assign done_entry_s = (state_r == ST_RUN) && (state_next_s == ST_DONE);

    // State register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: accept in IDLE, iterate in RUN, hold in DONE until taken.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (early_exit_s) begin
                    state_next_s = ST_DONE;
                end else if (cnt_r == LAST_STEP) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            ST_DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath registers: load operands on accept, advance one step per RUN
    // cycle, and freeze otherwise so input changes after accept are ignored.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            acc_r    <= {ACC_W{1'b0}};
            mshift_r <= {ACC_W{1'b0}};
            q_r      <= {Q_W{1'b0}};
            q_m1_r   <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        acc_r    <= {ACC_W{1'b0}};
                        mshift_r <= ext_m_s;
                        q_r      <= ext_q_s;
                        q_m1_r   <= 1'b0;
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (!early_exit_s) begin
                        acc_r    <= acc_walk_s;
                        mshift_r <= m_walk_s;
                        q_r      <= q_walk_s;
                        q_m1_r   <= q_m1_walk_s;
                        cnt_r    <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    acc_r    <= acc_r;
                    mshift_r <= mshift_r;
                    q_r      <= q_r;
                    q_m1_r   <= q_m1_r;
                    cnt_r    <= cnt_r;
                end
            endcase
        end
    end

    // Product register: updated only on entry to DONE, so it stays stable
    // through backpressure and keeps the last result while idle.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            product_r <= {(2 * W){1'b0}};
        end else if (done_entry_s) begin
            product_r <= result_s;
        end
    end

    assign product = product_r;

endmodule

// File: tb/tb_booth_radix4_seq.sv
// -----------------------------------------------------------------------------
// Testbench for booth_radix4_seq. Three instances (1, 2 and 4 digits per
// cycle, W = 32) run against a handshake/arithmetic model kept in the bench.
// The model predicts product, in_ready and out_valid from plain multiplication
// and from the step-count rules. A compare process checks every instance on
// every falling edge. Directed tests pin the model with hand-computed
// literals.
// -----------------------------------------------------------------------------
module tb_booth_radix4_seq;

    localparam int NI = 3;
`ifdef BOOTH_SEQ_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic        clk;
    logic        clear;
    logic        start_a     [NI];
    logic        smode_a     [NI];
    logic [31:0] mcand_a     [NI];
    logic [31:0] mplier_a    [NI];
    logic        in_ready_a  [NI];
    logic        out_valid_a [NI];
    logic        out_ready_a [NI];
    logic [63:0] prod_a      [NI];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state per instance: 0 idle, 1 busy, 2 result presented.
    int          m_phase [NI];
    int          m_rem   [NI];
    logic [63:0] m_prod  [NI];
    logic [63:0] m_pend  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        booth_radix4_seq #(
            .DATA_WIDTH      (32),
            .DIGITS_PER_CYCLE((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) u_dut (
            .clock       (clk),
            .clear       (clear),
            .start       (start_a[g]),
            .signed_mode (smode_a[g]),
            .multiplicand(mcand_a[g]),
            .multiplier  (mplier_a[g]),
            .in_ready    (in_ready_a[g]),
            .out_valid   (out_valid_a[g]),
            .out_ready   (out_ready_a[g]),
            .product     (prod_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dpc_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    // Exact 2W-bit product from ordinary multiplication of extended operands.
    function automatic logic [63:0] model_product(input logic [31:0] m, input logic [31:0] q,
                                                  input logic sm);
        logic [63:0] me;
        logic [63:0] qe;
        me = sm ? {{32{m[31]}}, m} : {32'd0, m};
        qe = sm ? {{32{q[31]}}, q} : {32'd0, q};
        return me * qe;
    endfunction

    // Cycles from accept to out_valid: ceil(17/dpc) steps, or with early exit
    // the number of steps taken before the remaining {q, q_m1} is uniform, + 1.
    function automatic int model_latency(input int dpc, input logic [31:0] q, input logic sm);
        int          steps;
        logic [34:0] r;
        int          early;
        steps = (17 + dpc - 1) / dpc;
        r     = {(sm ? {2{q[31]}} : 2'b00), q, 1'b0};
        early = steps;
        for (int k = 0; k < steps; k++) begin
            if (early == steps && (r == {35{1'b0}} || r == {35{1'b1}})) early = k + 1;
            r = 35'($signed(r) >>> (2 * dpc));
        end
        return EARLY_EXIT ? early : steps;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h (t=%0t)", name, idx, act, exp, $time);
        end
    endtask

    // Behavioural model of the handshake and result timing.
    always @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NI; i++) begin
                m_phase[i] <= 0;
                m_rem[i]   <= 0;
                m_prod[i]  <= 64'd0;
                m_pend[i]  <= 64'd0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                case (m_phase[i])
                    0: if (start_a[i]) begin
                        m_phase[i] <= 1;
                        m_rem[i]   <= model_latency(dpc_of(i), mplier_a[i], smode_a[i]);
                        m_pend[i]  <= model_product(mcand_a[i], mplier_a[i], smode_a[i]);
                    end
                    1: begin
                        m_rem[i] <= m_rem[i] - 1;
                        if (m_rem[i] == 1) begin
                            m_phase[i] <= 2;
                            m_prod[i]  <= m_pend[i];
                        end
                    end
                    default: if (out_ready_a[i]) m_phase[i] <= 0;
                endcase
            end
        end
    end

    // Compare process: every output of every instance, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                check("cyc_in_ready", i, 64'(in_ready_a[i]), 64'(m_phase[i] == 0));
                check("cyc_out_valid", i, 64'(out_valid_a[i]), 64'(m_phase[i] == 2));
                check("cyc_product", i, prod_a[i], m_prod[i]);
            end
        end
    end

    // One multiply on instance i; with bp set, junk inputs are driven during RUN
    // and out_ready is randomised while the result is presented.
    task automatic issue(input int i, input logic [31:0] m, input logic [31:0] q,
                         input logic sm, input bit bp, output logic [63:0] p, output int lat);
        int n;
        n = 0;
        while (!in_ready_a[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_in_ready", i, 64'(in_ready_a[i]), 64'd1);
        start_a[i]     = 1'b1;
        mcand_a[i]     = m;
        mplier_a[i]    = q;
        smode_a[i]     = sm;
        out_ready_a[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (lat < 40) begin
            start_a[i] = bp ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (bp) begin
                mcand_a[i]  = $urandom;
                mplier_a[i] = $urandom;
                smode_a[i]  = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid_a[i]) break;
        end
        start_a[i] = 1'b0;
        check("wait_out_valid", i, 64'(out_valid_a[i]), 64'd1);
        p = prod_a[i];
        n = 0;
        while (out_valid_a[i] && n < 50) begin
            out_ready_a[i] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        out_ready_a[i] = 1'b0;
        check("handoff_done", i, 64'(out_valid_a[i]), 64'd0);
    endtask

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p;
        logic [63:0] p0;
        int          lat;
        int          n;
        logic [31:0] rm;
        logic [31:0] rq;
        logic        rs;

        clear = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start_a[i] = 1'b0; smode_a[i] = 1'b0; mcand_a[i] = 32'd0;
            mplier_a[i] = 32'd0; out_ready_a[i] = 1'b0;
        end
        #1 clear = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("reset_in_ready", i, 64'(in_ready_a[i]), 64'd1);
            check("reset_out_valid", i, 64'(out_valid_a[i]), 64'd0);
            check("reset_product", i, prod_a[i], 64'd0);
        end
        #2 clear = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Directed products pinned by hand-computed values.
        issue(0, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, p, lat);
        check("signed_7xm3", 0, p, 64'hFFFF_FFFF_FFFF_FFEB);
`ifndef BOOTH_SEQ_EARLY_EXIT_EN
        check("latency_dpc1", 0, 64'(lat), 64'd17);
`endif
        issue(1, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, p, lat);
        check("signed_7xm3", 1, p, 64'hFFFF_FFFF_FFFF_FFEB);
`ifndef BOOTH_SEQ_EARLY_EXIT_EN
        check("latency_dpc2", 1, 64'(lat), 64'd9);
`endif
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, p, lat);
        check("unsigned_max_sq", 0, p, 64'hFFFF_FFFE_0000_0001);
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, p, lat);
        check("signed_m1_sq", 0, p, 64'h0000_0000_0000_0001);
        issue(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, p, lat);
        check("signed_min_sq", 0, p, 64'h4000_0000_0000_0000);
        issue(2, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, p, lat);
        check("signed_min_sq", 2, p, 64'h4000_0000_0000_0000);
`ifndef BOOTH_SEQ_EARLY_EXIT_EN
        check("latency_dpc4", 2, 64'(lat), 64'd5);
`endif
        issue(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, p, lat);
        check("unsigned_max_sq", 2, p, 64'hFFFF_FFFE_0000_0001);

`ifdef BOOTH_SEQ_EARLY_EXIT_EN
        issue(0, 32'd5, 32'd0, 1'b1, 1'b0, p, lat);
        check("early_q0_product", 0, p, 64'd0);
        check("early_q0_latency", 0, 64'(lat), 64'd1);
        issue(0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, p, lat);
        check("early_qm1_product", 0, p, 64'hFFFF_FFFF_FFFF_FFFB);
        check("early_qm1_latency", 0, 64'(lat), 64'd2);
        issue(0, 32'd100, 32'd3, 1'b1, 1'b0, p, lat);
        check("early_100x3_product", 0, p, 64'd300);
        check("early_100x3_latency", 0, 64'(lat), 64'd3);
`endif

        // Backpressure with an ignored start while the result is held.
        start_a[0] = 1'b1; mcand_a[0] = 32'h1234_5678; mplier_a[0] = 32'h9ABC_DEF0;
        smode_a[0] = 1'b0; out_ready_a[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_a[0] = 1'b0;
        n = 0;
        while (!out_valid_a[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_rise", 0, 64'(out_valid_a[0]), 64'd1);
        p0 = prod_a[0];
        check("bp_product", 0, p0, model_product(32'h1234_5678, 32'h9ABC_DEF0, 1'b0));
        for (int k = 0; k < 5; k++) begin
            start_a[0] = (k == 2);
            mcand_a[0] = $urandom;
            mplier_a[0] = $urandom;
            @(negedge clk);
            check("bp_hold_valid", 0, 64'(out_valid_a[0]), 64'd1);
            check("bp_hold_product", 0, prod_a[0], p0);
        end
        start_a[0] = 1'b0;
        out_ready_a[0] = 1'b1;
        @(negedge clk);
        check("bp_in_ready_after", 0, 64'(in_ready_a[0]), 64'd1);
        check("bp_valid_dropped", 0, 64'(out_valid_a[0]), 64'd0);
        out_ready_a[0] = 1'b0;
        @(negedge clk);
        check("bp_start_not_queued", 0, 64'(in_ready_a[0]), 64'd1);

        // Reset during the eighth RUN cycle, then a fresh multiply.
        start_a[0] = 1'b1; mcand_a[0] = $urandom; mplier_a[0] = $urandom; smode_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("pre_clear_busy", 0, 64'(in_ready_a[0]), 64'(EARLY_EXIT && m_phase[0] != 1));
        #2 clear = 1'b1;
        #1;
        check("clear_in_ready", 0, 64'(in_ready_a[0]), 64'd1);
        check("clear_out_valid", 0, 64'(out_valid_a[0]), 64'd0);
        check("clear_product", 0, prod_a[0], 64'd0);
        @(negedge clk);
        #2 clear = 1'b0;
        issue(0, 32'd5, 32'd6, 1'b0, 1'b0, p, lat);
        check("after_clear_5x6", 0, p, 64'd30);

        // Randomised operands, modes and backpressure on every configuration.
        for (int i = 0; i < NI; i++) begin
            for (int t = 0; t < 30; t++) begin
                rm = pick();
                rq = pick();
                rs = 1'($urandom_range(0, 1));
                issue(i, rm, rq, rs, 1'b1, p, lat);
                check("rand_product", i, p, model_product(rm, rq, rs));
                check("rand_latency", i, 64'(lat), 64'(model_latency(dpc_of(i), rq, rs)));
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_radix4_seq.md
# booth_radix4_seq

Iterative, parametrised radix-4 Booth multiplier for the ALU multiply path. It replaces a single-cycle combinational partial-product array with a shift/add datapath. That datapath retires `DIGITS_PER_CYCLE` Booth digits per clock and supports both signed and unsigned operands. Operands enter through a start/ready handshake and the double-width product leaves through a valid/ready handshake, so the control unit can stall the pipeline on `in_ready`/`out_valid`.

## Interface
- `DATA_WIDTH`, 32: operand width; must be even and ≥ 4.
- `DIGITS_PER_CYCLE`, 1: Booth digits retired per RUN cycle; legal values are 1, 2 and 4.
- `clock`  in  1  single clock, rising edge.
- `clear`  in  1  reset, asynchronous, active-high.
- `start`  in  1  operand-valid strobe; accepted only when `in_ready`=1.
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- `multiplicand`  in  DATA_WIDTH  operand M, sampled at accept.
- `multiplier`  in  DATA_WIDTH  operand Q, sampled at accept.
- `in_ready`  out  1  high only in IDLE.
- `out_valid`  out  1  high only in DONE.
- `out_ready`  in  1  consumer accepts `product` when `out_valid`=1.
- `product`  out  2*DATA_WIDTH  result; stable while `out_valid`=1.

## Operation
- **Extension:** let W = DATA_WIDTH.
  - Both operands are extended to W+2 bits: sign-extended if `signed_mode`=1, zero-extended if 0.
  - N = W/2+1 digits; S = ceil(N/DIGITS_PER_CYCLE) steps.
- **Registers:** accumulator `acc` (2W+2 bits), shifted multiplicand `mshift` (2W+2 bits), multiplier shift register `q` with appended low bit `q_m1`, and step counter `cnt`.
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `start`: load operands, set `acc`=0, `q_m1`=0, `cnt`=0, and go to RUN.
- **RUN:** for each of the DIGITS_PER_CYCLE digits in the cycle, decode {q[1],q[0],q_m1}:
  - 000 and 111 → 0
  - 001 and 010 → +M
  - 011 → +2M
  - 100 → −2M
  - 101 and 110 → −M
  - Add the decoded multiple of `mshift` to `acc`, shift `mshift` left by 2, shift `q` right by 2 arithmetically, and set `q_m1`=q[1].
  - Digits beyond N decode to 0 by construction, because they are sign or zero extension.
  - After step S (`cnt`=S−1), go to DONE.
- **DONE:**
  - `product` = acc[2W−1:0]; truncation is exact for both modes.
  - `out_valid`=1. On `out_ready`, go to IDLE.
- `start` outside IDLE is ignored; no queueing.
- Changing inputs during RUN or DONE has no effect.
- **Reset:** `clear` at any time, including mid-RUN, forces IDLE, `in_ready`=1, `out_valid`=0, `product`=0. The in-flight operation is discarded.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `product`=0; all internal registers are 0.
- **Accept:** rising edge E0 with `start`·`in_ready`. `in_ready` is low from the cycle after E0.
- **Latency:** `out_valid` rises after edge E0+S.
  - W=32, DPC=1 → 17 cycles; DPC=2 → 9 cycles; DPC=4 → 5 cycles.
- **Handoff:** DONE→IDLE on the edge where `out_valid`·`out_ready`=1. `in_ready` is 1 the next cycle, so the minimum issue interval is S+2 cycles.
- **Registered outputs:** `product` is registered and changes only on entry to DONE or on reset.

## Configuration
- **`BOOTH_SEQ_EARLY_EXIT_EN` defined:**
  - In RUN, before each step, if all remaining bits of {q, q_m1} are equal (all 0 or all 1), go directly to DONE without adding.
  - That check costs one cycle, so latency = (steps with a non-zero remaining digit) + 1.
  - Results are identical to the undefined case.
- **Undefined:** fixed latency S; no early-exit comparator is synthesised.

## Test plan
- **Signed:** W=32, DPC=1, signed, 7 × −3 → `product`=0xFFFF_FFFF_FFFF_FFEB; `out_valid` exactly 17 cycles after accept.
- **Unsigned corner:** 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFF_FFFE_0000_0001. The same operands in signed mode → 0x0000_0000_0000_0001.
- **Signed corner:** 0x80000000 × 0x80000000, signed → 0x4000_0000_0000_0000; with DPC=4 the result is the same, with `out_valid` after 5 cycles.
- **Backpressure and ignored start:**
  - Hold `out_ready`=0 for 5 cycles after `out_valid` → `product` and `out_valid` stay stable.
  - A `start` pulse during that window is ignored.
  - `in_ready`=1 on the cycle after `out_ready`.
- **Reset mid-operation:** assert `clear` at cycle 8 of RUN → same cycle, `in_ready`=1, `out_valid`=0, `product`=0. A new multiply of 5 × 6 then yields 30.
- **Early exit (`BOOTH_SEQ_EARLY_EXIT_EN` defined), signed:**
  - Multiplier 0 → latency 1.
  - Multiplier −1 → latency 2.
  - 100 × 3 → 300 with latency 3.
  - Random operand pairs → products match the non-early-exit build.
